// File: rtl/mandelbrot_stream.sv
// Paces the mandelbrot pixel engine one run at a time, packs two 4-bit results per byte
// into a small FIFO and streams the bytes out on valid/ready with a frame-last tag.
`timescale 1ns/1ps

module mandelbrot_stream_chk #(
   parameter int DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic push_i,
   input  logic full_i
);
   // Runs are only issued with a free slot, so a capture can never find the FIFO full.
   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push_i && full_i))
      else $error("push into full FIFO (DEPTH=%0d)", DEPTH);
endmodule

module mandelbrot_stream #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   output logic       mb_run,
   input  logic       mb_running,
   input  logic [3:0] mb_ctr_out,
   input  logic       mb_finished,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       frame_done
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state_q;
   logic            wait_first_q;
   logic            half_q;
   logic [3:0]      nib_q;
   logic            frame_done_q;
   logic [8:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;

   logic            capture_s;
   logic            push_s;
   logic [8:0]      push_word_s;
   logic            pop_s;
   logic [8:0]      head_s;

   assign mb_run     = (state_q == ISSUE) && (count_q < DEPTH_C) && !stop;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign out_valid  = (count_q != {CW{1'b0}});
   assign head_s     = mem_q[rd_ptr_q];
   assign out_data   = out_valid ? head_s[7:0] : 8'h00;
   assign out_last   = out_valid ? head_s[8] : 1'b0;
   assign pop_s      = out_valid && out_ready;

   // Capture decode: the first WAIT cycle always sees the engine running, so it is skipped.
   always_comb begin
      capture_s   = (state_q == WAIT) && !wait_first_q && !mb_running;
      push_s      = 1'b0;
      push_word_s = 9'h000;
      if (capture_s) begin
         push_s = half_q || mb_finished || stop;
         if (half_q) begin
            push_word_s = {mb_finished, mb_ctr_out, nib_q};
         end else begin
            push_word_s = {mb_finished, 4'h0, mb_ctr_out};
         end
      end else begin
         push_s      = 1'b0;
         push_word_s = 9'h000;
      end
   end

   // Frame sequencer: issue, wait for the result, pack, and end on last or stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wait_first_q <= 1'b0;
         half_q       <= 1'b0;
         nib_q        <= 4'h0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               half_q <= 1'b0;
               nib_q  <= 4'h0;
               if (start && !stop) state_q <= ISSUE;
               else                state_q <= IDLE;
            end
            ISSUE: begin
               if (stop) begin
                  state_q <= DRAIN;
               end else if (mb_run) begin
                  state_q      <= WAIT;
                  wait_first_q <= 1'b1;
               end else begin
                  state_q <= ISSUE;
               end
            end
            WAIT: begin
               wait_first_q <= 1'b0;
               if (capture_s) begin
                  if (!half_q) nib_q <= mb_ctr_out;
                  half_q <= !half_q && !push_s;
                  if (push_s && mb_finished) begin
                     frame_done_q <= 1'b1;
                     state_q      <= IDLE;
                  end else if (stop) begin
                     state_q <= DRAIN;
                  end else begin
                     state_q <= ISSUE;
                  end
               end else begin
                  state_q <= WAIT;
               end
            end
            DRAIN: begin
               if (count_q == {CW{1'b0}}) state_q <= IDLE;
               else                       state_q <= DRAIN;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Occupancy: simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Byte FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 9'h000;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_s) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   mandelbrot_stream_chk #(.DEPTH(DEPTH)) u_chk (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .push_i  (push_s),
      .full_i  (count_q == DEPTH_C)
   );
endmodule

// File: tb/tb_mandelbrot_stream.sv
// Scoreboard bench for mandelbrot_stream with a behavioural pixel engine and random pixels.
`timescale 1ns/1ps

module tb_mandelbrot_stream;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mb_run;
   logic       mb_running;
   logic [3:0] mb_ctr_out;
   logic       mb_finished;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       busy;
   logic       frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_runs   = 0;
   int fd_cnt   = 0;
   int rdy_mode = 0;

   logic [8:0] exp_q [$];
   logic [3:0] pix_q [$];

   logic       eng_running = 1'b0;
   logic       eng_fin = 1'b0;
   logic [3:0] eng_ctr = 4'h0;
   int         eng_cnt = 0;

   assign mb_running  = eng_running;
   assign mb_ctr_out  = eng_ctr;
   assign mb_finished = eng_fin;

   mandelbrot_stream #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .mb_run      (mb_run),
      .mb_running  (mb_running),
      .mb_ctr_out  (mb_ctr_out),
      .mb_finished (mb_finished),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Engine: run sampled on an edge, result and finished appear together when it stops.
   initial begin
      forever begin
         @(posedge clk);
         if (mb_run) begin
            n_runs++;
            eng_running <= 1'b1;
            eng_cnt     <= int'($urandom_range(0, 3));
         end else if (eng_running) begin
            if (eng_cnt == 0) begin
               eng_running <= 1'b0;
               if (pix_q.size() > 0) begin
                  eng_ctr <= pix_q[0];
                  eng_fin <= (pix_q.size() == 1);
                  void'(pix_q.pop_front());
               end
            end else begin
               eng_cnt <= eng_cnt - 1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every accepted byte is popped from the scoreboard and compared.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_byte: got 0x%0h, expected no byte at %0t", {out_last, out_data}, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("byte", 32'({out_last, out_data}), 32'(e));
               end
            end else if (!out_valid) begin
               chk("idle_out_zero", 32'({out_last, out_data}), 0);
            end
         end
      end
   end

   // Reference packing: pairs low-first, odd tail padded with zero, last only on a complete frame.
   task automatic load_frame(input logic [3:0] px [$], input int k);
      int n;
      logic lst;
      n = px.size();
      for (int i = 0; i < k; i += 2) begin
         if (i + 1 < k) begin
            lst = (i + 1 == n - 1);
            exp_q.push_back({lst, px[i+1], px[i]});
         end else begin
            lst = (i == n - 1);
            exp_q.push_back({lst, 4'h0, px[i]});
         end
      end
      pix_q = px;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk(nm, 32'(c < budget), 1);
   endtask

   task automatic wait_runs(input int target, input int r0);
      int c;
      c = 0;
      while (n_runs - r0 < target && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      chk("run_wait_bound", 32'(c < 300), 1);
   endtask

   initial begin
      logic [3:0] px [$];
      int r0;
      int f0;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mb_run", 32'(mb_run), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Nominal frame 1..8
      rdy_mode = 0;
      px = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      load_frame(px, 8);
      f0 = fd_cnt;
      pulse_start();
      chk("run_after_start", 32'(mb_run), 1);
      wait_done("nominal_timeout", 500);
      @(negedge clk);
      chk("nominal_frame_done", fd_cnt - f0, 1);
      chk("nominal_idle", 32'(busy), 0);

      // start together with stop stays idle
      r0 = n_runs;
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      chk("start_stop_idle", 32'(busy), 0);
      repeat (3) @(posedge clk);
      #1 chk("start_stop_no_run", n_runs - r0, 0);

      // Backpressure: ready low for 200 cycles
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(4'($urandom_range(0, 15)));
      load_frame(px, 16);
      r0 = n_runs;
      f0 = fd_cnt;
      pulse_start();
      repeat (200) @(posedge clk);
      #1;
      chk("bp_runs_held", n_runs - r0, 8);
      chk("bp_run_low_full", 32'(mb_run), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_busy", 32'(busy), 1);
      rdy_mode = 2;
      wait_done("bp_timeout", 2000);
      chk("bp_total_runs", n_runs - r0, 16);
      chk("bp_frame_done", fd_cnt - f0, 1);

      // Odd frame 5,6,7
      rdy_mode = 0;
      px = {4'd5, 4'd6, 4'd7};
      load_frame(px, 3);
      f0 = fd_cnt;
      pulse_start();
      wait_done("odd_timeout", 500);
      chk("odd_frame_done", fd_cnt - f0, 1);

      // Stop one cycle after third run
      px = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      load_frame(px, 3);
      r0 = n_runs;
      f0 = fd_cnt;
      pulse_start();
      wait_runs(3, r0);
      stop = 1'b1;
      wait_done("stop_timeout", 500);
      repeat (4) @(posedge clk);
      #1;
      chk("stop_no_fourth_run", n_runs - r0, 3);
      chk("stop_no_frame_done", fd_cnt - f0, 0);
      chk("stop_idle", 32'(busy), 0);
      stop = 1'b0;
      pix_q.delete();

      // Asynchronous reset in WAIT with two bytes queued and a nibble latched
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      px.delete();
      for (int i = 0; i < 8; i++) px.push_back(4'($urandom_range(0, 15)));
      pix_q = px;
      r0 = n_runs;
      pulse_start();
      wait_runs(6, r0);
      chk("rst_mid_valid_before", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_run", 32'(mb_run), 0);
      chk("rst_mid_data", 32'(out_data), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      repeat (8) @(posedge clk);
      #1 pix_q.delete();
      px.delete();
      for (int i = 0; i < 5; i++) px.push_back(4'($urandom_range(0, 15)));
      load_frame(px, 5);
      f0 = fd_cnt;
      pulse_start();
      wait_done("post_rst_timeout", 500);
      chk("post_rst_frame_done", fd_cnt - f0, 1);

      // Random ready: push/pop collisions must keep count and order
      rdy_mode = 2;
      px.delete();
      for (int i = 0; i < 40; i++) px.push_back(4'($urandom_range(0, 15)));
      load_frame(px, 40);
      f0 = fd_cnt;
      pulse_start();
      wait_done("rand_timeout", 5000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rand_frame_done", fd_cnt - f0, 1);
      chk("rand_fifo_empty", 32'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
